priority_request_tracker: RTL and testbench
===========================================

Name: priority_request_tracker

Overview:
- Upstream stage of the priority encoder.
- Captures single-cycle request pulses into a sticky pending register and applies a per-bit enable mask.
- Offers the highest-index pending request as a registered index with valid/ready handshake; clears that bit when the consumer accepts it.
- Typical use: interrupt/event aggregation in front of a sequential consumer such as a dispatcher or CPU IRQ port.

Parameters:
- DATA_WIDTH, 8, number of request lines; legal range 2..64.
- IDX_WIDTH, $clog2(DATA_WIDTH), width of offered index; derived, never overridden.
- CNT_WIDTH, 8, width of the per-tracker overflow counter; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_i  in  DATA_WIDTH  request pulses; bit n high for one cycle latches request n.
- mask_i  in  DATA_WIDTH  enable mask; 1 = request eligible for offering. Pending bits are latched regardless of mask.
- pending_o  out  DATA_WIDTH  current pending register, unmasked.
- idx_o  out  IDX_WIDTH  offered request index, registered.
- valid_o  out  1  idx_o valid.
- ready_i  in  1  consumer accepts idx_o when valid_o && ready_i at a rising clk.
- ovf_cnt_o  out  CNT_WIDTH  overflow count; exists only with PRT_OVF_CNT_EN.

Behaviour:
- Reset (async assert, synchronous release): pending=0, state=IDLE, valid_o=0, idx_o=0, ovf_cnt_o=0.
- Pending update per edge: pending_next = (pending & ~clr) | req_i.
  - clr is a one-hot of idx_o when the handshake fires, otherwise 0.
  - Set wins: a req_i pulse on the bit being cleared leaves it pending, so the request is re-offered later.
- Eligible vector = pending & mask_i, fed combinationally to a priority_encoder instance (highest set bit wins).
- FSM states: IDLE, OFFER.
  - IDLE: if eligible != 0, load idx_o with the encoder output, set valid_o=1, go to OFFER. Otherwise stay and hold valid_o=0.
  - OFFER: idx_o and valid_o are held stable while ready_i=0; no withdrawal even if mask_i drops that bit.
  - OFFER with ready_i=1 at an edge: clear pending[idx_o], valid_o=0, go to IDLE.
- Latency: req_i pulse sampled at edge k; pending set after k; valid_o high after edge k+1 (1-cycle pending-to-offer).
- Throughput: at most one acceptance per 2 cycles, because a mandatory IDLE bubble follows each handshake.
- Priority is evaluated only in IDLE. A higher request arriving during OFFER waits for the next IDLE evaluation.
- ready_i while valid_o=0 is ignored.
- All requests masked: stay in IDLE, pending bits retained, offered once unmasked.
- All bits pending: offered in order DATA_WIDTH-1 down to 0 when no new requests arrive.
- Reset asserted mid-OFFER: valid_o drops asynchronously; all pending requests are lost.

Optional Feature:
- Macro: PRT_OVF_CNT_EN.
- With the macro defined: ovf_cnt_o counts edges where req_i[n]=1 while pending[n]=1 and bit n is not being cleared on that edge.
  - Multiple such bits on one edge increment by 1 total.
  - The counter saturates at all-ones.
  - Reset clears it to 0.
- Without the macro: ovf_cnt_o port and counter are absent. No other behaviour changes.

Decomposition:
- New package priority_request_package:
  - typedef enum logic {PRT_IDLE, PRT_OFFER} prt_state_t.
  - Default DATA_WIDTH and CNT_WIDTH localparams.
- Sub-module: existing priority_encoder, CORE_VERSION `V2_GENERIC, DATA_WIDTH passed through.
  - Its valid_o serves as the eligible-nonzero flag.
- Tracker logic is otherwise flat: pending register, FSM, output register, optional counter.

Test Plan (DATA_WIDTH=8, mask_i=8'hFF unless stated):
- Single pulse req_i=8'b0000_1000 for one cycle, ready_i=1 -> valid_o high one edge after pending_o=8'h08 with idx_o=3. Next edge valid_o=0, pending_o=0.
- Pulse 8'b1100_0001 at once, ready_i=1 -> idx_o sequence 7, 6, 0, each valid for one cycle with an IDLE bubble between. pending_o ends at 0.
- Backpressure: req 8'h02, ready_i=0 for 5 cycles, then req 8'h80 arrives during OFFER -> idx_o stays 1 and stable. After ready_i=1, next offer is idx_o=7.
- Mask: pending 8'h90, mask_i=8'h0F -> valid_o stays 0. Set mask_i=8'hFF -> idx_o=7, then 4.
- Set-wins: offering idx 5, pulse req_i=8'h20 on the same edge ready_i=1 -> pending_o bit 5 remains 1 and idx 5 is re-offered after the bubble. With PRT_OVF_CNT_EN, ovf_cnt_o stays 0 in this case. A repeat pulse on bit 5 one cycle later while it is pending and not being cleared -> ovf_cnt_o=1.
- Reset mid-OFFER: rst asserted asynchronously between edges -> valid_o, pending_o, idx_o are 0 immediately, before the next edge.

Source files
------------

// File: rtl/priority_request_tracker_pkg.sv
// Shared types and defaults for the priority request tracker.
// V2_GENERIC selects the generic priority_encoder core.
`ifndef V2_GENERIC
`define V2_GENERIC 2
`endif

package priority_request_package;

    typedef enum logic {PRT_IDLE, PRT_OFFER} prt_state_t;

    localparam int PRT_DATA_WIDTH = 8;
    localparam int PRT_CNT_WIDTH  = 8;

endpackage

// File: rtl/priority_request_tracker_encoder.sv
// Combinational priority encoder: the highest set bit of data_i wins.
// valid_o is high when any bit is set.
module priority_encoder #(
    parameter int DATA_WIDTH   = 8,
    parameter int CORE_VERSION = `V2_GENERIC,
    localparam int IDX_WIDTH   = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [IDX_WIDTH-1:0]  idx_o,
    output logic                  valid_o
);

    generate
        if (CORE_VERSION == `V2_GENERIC) begin : g_v2
            // Ascending scan; later (higher) hits overwrite earlier ones.
            always_comb begin
                idx_o = '0;
                for (int i = 0; i < DATA_WIDTH; i++)
                    if (data_i[i]) idx_o = IDX_WIDTH'(i);
            end
        end else begin : g_v1
            always_comb begin
                logic found;
                idx_o = '0;
                found = 1'b0;
                for (int i = DATA_WIDTH - 1; i >= 0; i--)
                    if (data_i[i] && !found) begin
                        idx_o = IDX_WIDTH'(i);
                        found = 1'b1;
                    end
            end
        end
    endgenerate

    assign valid_o = |data_i;

endmodule

// File: rtl/priority_request_tracker.sv
// Sticky request tracker offering the highest eligible pending index over valid/ready.
// Optional overflow counter enabled by defining PRT_OVF_CNT_EN.
module priority_request_tracker
    import priority_request_package::*;
#(
    parameter int DATA_WIDTH = PRT_DATA_WIDTH,
    parameter int CNT_WIDTH  = PRT_CNT_WIDTH,
    localparam int IDX_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] req_i,
    input  logic [DATA_WIDTH-1:0] mask_i,
    output logic [DATA_WIDTH-1:0] pending_o,
    output logic [IDX_WIDTH-1:0]  idx_o,
    output logic                  valid_o,
    input  logic                  ready_i
`ifdef PRT_OVF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  ovf_cnt_o
`endif
);

    prt_state_t            state, state_next;
    logic [DATA_WIDTH-1:0] pending, pending_next, clr, eligible;
    logic [IDX_WIDTH-1:0]  idx_next, enc_idx;
    logic                  enc_valid, fire;

    assign fire         = (state == PRT_OFFER) && ready_i;
    assign clr          = fire ? (DATA_WIDTH'(1) << idx_o) : '0;
    // Set wins over clear so a re-pulse on the accepted bit is not lost.
    assign pending_next = (pending & ~clr) | req_i;
    assign eligible     = pending & mask_i;

    priority_encoder #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CORE_VERSION(`V2_GENERIC)
    ) u_enc (
        .data_i (eligible),
        .idx_o  (enc_idx),
        .valid_o(enc_valid)
    );

    always_comb begin
        state_next = state;
        idx_next   = idx_o;
        case (state)
            PRT_IDLE: begin
                if (enc_valid) begin
                    state_next = PRT_OFFER;
                    idx_next   = enc_idx;
                end
            end
            PRT_OFFER: begin
                // Offer is never withdrawn, even if the mask drops the bit.
                if (ready_i) state_next = PRT_IDLE;
            end
            default: state_next = PRT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= PRT_IDLE;
            pending <= '0;
            idx_o   <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            idx_o   <= idx_next;
        end
    end

    assign valid_o   = (state == PRT_OFFER);
    assign pending_o = pending;

`ifdef PRT_OVF_CNT_EN
    logic overflow;
    // A pulse on a still-pending bit that is not being retired is a lost event.
    assign overflow = |(req_i & pending & ~clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_cnt_o <= '0;
        else if (overflow && !(&ovf_cnt_o))
            ovf_cnt_o <= ovf_cnt_o + 1'b1;
    end
`endif

endmodule

// File: tb/tb_priority_request_tracker.sv
// Directed bench for priority_request_tracker with an accepted-index scoreboard.
// Overflow-count checks are compiled in when PRT_OVF_CNT_EN is defined.
module tb_priority_request_tracker;

    localparam int DW = 8;
    localparam int IW = $clog2(DW);
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] req, mask, pending;
    logic [IW-1:0] idx;
    logic          valid, ready;
`ifdef PRT_OVF_CNT_EN
    logic [CW-1:0] ovf_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int sb[$];

    always #5 clk = ~clk;

    priority_request_tracker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .mask_i   (mask),
        .pending_o(pending),
        .idx_o    (idx),
        .valid_o  (valid),
        .ready_i  (ready)
`ifdef PRT_OVF_CNT_EN
        ,
        .ovf_cnt_o(ovf_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each handshake seen pops the next expected index.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_accept", 64'(idx), 64'hFFFF);
            end else begin
                int e;
                e = sb.pop_front();
                check("sb_accept_idx", 64'(idx), 64'(e));
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; mask = 8'hFF; ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        check("reset_pending", 64'(pending), 0);
        check("reset_valid", 64'(valid), 0);
        check("reset_idx", 64'(idx), 0);
`ifdef PRT_OVF_CNT_EN
        check("reset_ovf", 64'(ovf_cnt), 0);
`endif

        // Single pulse, one-cycle pending-to-offer latency
        req = 8'h08; ready = 1'b1; sb.push_back(3);
        step(); req = '0;
        check("single_pending", 64'(pending), 8'h08);
        check("single_valid_early", 64'(valid), 0);
        step();
        check("single_valid", 64'(valid), 1);
        check("single_idx", 64'(idx), 3);
        step();
        check("single_done_valid", 64'(valid), 0);
        check("single_done_pending", 64'(pending), 0);

        // Three bits at once: 7, 6, 0 with bubbles between
        req = 8'hC1; sb.push_back(7); sb.push_back(6); sb.push_back(0);
        step(); req = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("multi_valid_bubble", 64'(valid), (i % 2 == 0) ? 1 : 0);
        end
        check("multi_pending_end", 64'(pending), 0);

        // Backpressure: offer held while a higher request arrives
        ready = 1'b0; req = 8'h02; sb.push_back(1); sb.push_back(7);
        step(); req = '0;
        step();
        check("bp_valid", 64'(valid), 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) req = 8'h80;
            step(); req = '0;
            check("bp_idx_hold", 64'(idx), 1);
            check("bp_valid_hold", 64'(valid), 1);
        end
        check("bp_pending", 64'(pending), 8'h82);
        ready = 1'b1;
        step();
        check("bp_bubble", 64'(valid), 0);
        step();
        check("bp_next_idx", 64'(idx), 7);
        step();
        check("bp_pending_end", 64'(pending), 0);

        // Masked requests retained until unmasked
        ready = 1'b0; mask = 8'h0F; req = 8'h90;
        step(); req = '0;
        step(); step();
        check("mask_valid_low", 64'(valid), 0);
        check("mask_pending", 64'(pending), 8'h90);
        mask = 8'hFF; ready = 1'b1; sb.push_back(7); sb.push_back(4);
        step();
        check("mask_idx7", 64'(idx), 7);
        step(); step();
        check("mask_idx4", 64'(idx), 4);
        check("mask_valid4", 64'(valid), 1);
        step();
        check("mask_pending_end", 64'(pending), 0);

        // Set wins over clear on the accepted bit
        ready = 1'b0; req = 8'h20;
        step(); req = '0;
        step();
        check("sw_offer_idx", 64'(idx), 5);
        ready = 1'b1; req = 8'h20; sb.push_back(5);
        step(); ready = 1'b0; req = '0;
        check("sw_pending_kept", 64'(pending), 8'h20);
        check("sw_bubble", 64'(valid), 0);
`ifdef PRT_OVF_CNT_EN
        check("sw_ovf_zero", 64'(ovf_cnt), 0);
`endif
        req = 8'h20;
        step(); req = '0;
        check("sw_reoffer_valid", 64'(valid), 1);
        check("sw_reoffer_idx", 64'(idx), 5);
`ifdef PRT_OVF_CNT_EN
        check("sw_ovf_one", 64'(ovf_cnt), 1);
`endif
        ready = 1'b1; sb.push_back(5);
        step(); ready = 1'b0;
        check("sw_pending_end", 64'(pending), 0);

        // Asynchronous reset in the middle of an offer
        req = 8'h40;
        step(); req = '0;
        step();
        check("rst_pre_valid", 64'(valid), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(valid), 0);
        check("rst_async_pending", 64'(pending), 0);
        check("rst_async_idx", 64'(idx), 0);
`ifdef PRT_OVF_CNT_EN
        check("rst_async_ovf", 64'(ovf_cnt), 0);
`endif
        step();
        rst = 1'b0;
        step(); step();
        check("rst_after_valid", 64'(valid), 0);

        check("sb_drained", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
